// File: rtl/regfile_write_sched.sv
// Register-file write-port arbiter (WB vs aux) with a RAW pending-write scoreboard.
// Optional RF_FWD_EN adds same-cycle WB-to-ID forwarding outputs.
module regfile_write_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_reg,
    input  logic [DATA_W-1:0] aux_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  pending
`ifdef RF_FWD_EN
    ,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    typedef enum logic {
        LAST_WB,
        LAST_AUX
    } rr_t;

    rr_t              rr_q;
    rr_t              rr_d;
    logic             aux_elig;
    logic             aux_req;
    logic             wb_xfer;
    logic             aux_xfer;
    logic [NREGS-1:0] pend_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= LAST_AUX;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Ready reflects "would be accepted", so it is meaningful even while idle.
    always_comb begin
        aux_elig  = !pending[aux_reg];
        aux_req   = aux_valid && aux_elig;
        wb_ready  = !(aux_req && rr_q == LAST_WB);
        aux_ready = aux_elig && !(wb_valid && rr_q == LAST_AUX);
        wb_xfer   = wb_valid && wb_ready;
        aux_xfer  = aux_valid && aux_ready;
        rr_d      = rr_q;
        if (wb_valid && aux_req) begin
            rr_d = wb_xfer ? LAST_WB : LAST_AUX;
        end
    end

    // Clear first, then set, so a same-cycle reservation survives.
    always_comb begin
        pend_d = pending;
        if (wb_xfer) begin
            pend_d[wb_reg] = 1'b0;
        end
        if (rsv_valid && rsv_reg != '0) begin
            pend_d[rsv_reg] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_xfer) begin
            rf_we    <= wb_reg != '0;
            rf_waddr <= wb_reg;
            rf_wdata <= wb_data;
        end else if (aux_xfer) begin
            rf_we    <= aux_reg != '0;
            rf_waddr <= aux_reg;
            rf_wdata <= aux_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef RF_FWD_EN
    always_comb begin
        fwd_hit1  = wb_xfer && wb_reg == rd_reg1 && rd_reg1 != '0;
        fwd_hit2  = wb_xfer && wb_reg == rd_reg2 && rd_reg2 != '0;
        fwd_data1 = fwd_hit1 ? wb_data : '0;
        fwd_data2 = fwd_hit2 ? wb_data : '0;
        stall     = (pending[rd_reg1] && rd_reg1 != '0 && !fwd_hit1)
                  || (pending[rd_reg2] && rd_reg2 != '0 && !fwd_hit2);
    end
`else
    always_comb begin
        stall = (pending[rd_reg1] && rd_reg1 != '0)
             || (pending[rd_reg2] && rd_reg2 != '0);
    end
`endif

endmodule
